scan_window_sequencer: RTL and testbench
========================================

// Module: scan_window_sequencer
// PURPOSE
// - Control FSM sitting directly upstream of vj_pipeline: walks every 24x24 scanning window over every pyramid level.
// - Drives img_index/row_index/col_index into the integral-image window mux and vj_enable/vj_reset into vj_pipeline.
// - Supplies scanning_window_coords per window, then flushes the pipeline so the last window's verdict reaches face_coords.
// PARAMETERS
// - NUM_LEVELS    13                     pyramid levels, level 0 = full image
// - WIN           24                     window side in pixels
// - COORD_W       32                     width of index/coordinate fields
// - PIPE_DEPTH    2914                   vj_pipeline shift depth; number of flush cycles after the last window
// - LEVEL_WIDTHS  pkg PYRAMID_WIDTHS     [NUM_LEVELS-1:0][15:0] valid width per level
// - LEVEL_HEIGHTS pkg PYRAMID_HEIGHTS    [NUM_LEVELS-1:0][15:0] valid height per level
// PORTS
// - clock          in   1              single clock, all logic on posedge
// - reset_n        in   1              synchronous, active-low reset
// - start          in   1              pulse: pyramid + integral images are stable, begin a frame scan
// - stall          in   1              hold: freeze indices and pipeline this cycle
// - busy           out  1              high from accepted start until done
// - done           out  1              one-cycle pulse after flush completes
// - img_index      out  4              current pyramid level
// - row_index      out  COORD_W        window top row within level
// - col_index      out  COORD_W        window left column within level
// - vj_enable      out  1              advance vj_pipeline one stage
// - vj_reset       out  1              one-cycle clear of vj_pipeline at frame start
// - scanning_window_coords out [3:0][COORD_W]  {col+WIN-1, col, row+WIN-1, row} ([0]=row)
// - window_count   out  COORD_W        windows issued this frame
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state IDLE; all outputs 0 (busy, done, vj_enable, vj_reset, indices, coords, count).
// - All outputs registered. States: IDLE -> CLEAR -> SCAN -> DRAIN -> DONE -> IDLE.
// - IDLE: start=1 -> CLEAR; window_count<=0; indices<=first usable level, row 0, col 0. busy=1 from CLEAR to DONE inclusive.
// - CLEAR: vj_reset=1 for exactly one cycle, vj_enable=0; -> SCAN. First window presented cycle start+2.
// - SCAN: each non-stalled cycle: vj_enable=1, current indices/coords valid, window_count+=1, then advance:
//   col+1 while col < W[l]-WIN; else col=0,row+1 while row < H[l]-WIN; else next usable level, row=col=0.
// - Usable level: W[l]>=WIN and H[l]>=WIN; unusable levels skipped with zero cycles spent. No usable level: CLEAR -> DRAIN directly.
// - Window count per level = (W-WIN+1)*(H-WIN+1). Last window of last usable level -> DRAIN.
// - DRAIN: vj_enable=1 for PIPE_DEPTH non-stalled cycles, indices held at last window, window_count frozen; -> DONE.
// - DONE: done=1, busy=1 for one cycle; -> IDLE. busy and done deassert together next cycle.
// - stall=1 (SCAN or DRAIN): vj_enable=0, indices/count/drain counter hold; stall ignored in IDLE/CLEAR/DONE.
// - start while busy: ignored. start and stall same cycle in IDLE: start accepted.
// - reset_n low mid-scan: back to IDLE next edge, outputs as reset; no done pulse.
// - Arithmetic: index compares unsigned at COORD_W; coords row+WIN-1, col+WIN-1 never exceed level bound-1.
// STRUCTURE
// - Package vj_pkg: PYRAMID_WIDTHS/HEIGHTS, NUM_LEVELS, WIN, PIPE_DEPTH constants; enum scan_state_t {IDLE,CLEAR,SCAN,DRAIN,DONE}.
// - Sub-module level_skip_finder: combinational, given current level returns next usable level + last_level flag.
// - Drain counter: $clog2(PIPE_DEPTH+1) bits.
// TESTING (bench params: NUM_LEVELS=2, W={32,26}, H={28,25}, PIPE_DEPTH=4)
// - Reset then idle 10 cycles -> busy/done/vj_enable/vj_reset stay 0, indices 0.
// - start pulse, no stall -> vj_reset high at cycle 1; 45 windows level 0 (cols 0..8, rows 0..4), 6 windows level 1
//   (cols 0..2, rows 0..1); window_count=51; 4 drain cycles; done pulse at cycle 1+1+51+4=57 after start.
// - Check coords at level-0 window (row 2,col 5) -> {28,5,25,2}; order strictly col-inner, row, level.
// - stall high 3 cycles mid-level-0 and 2 cycles in DRAIN -> vj_enable 0 those cycles, indices unchanged, done 5 cycles later.
// - W={32,20}: level 1 unusable -> skipped, 45 windows total; all levels unusable -> CLEAR, 4 drain, done, count 0.
// - reset_n low during SCAN window 20 -> IDLE, all outputs 0, no done; second start ignored while busy.

Source files
------------

// File: rtl/vj_pkg.sv
// Shared constants and types for the Viola-Jones scan front end.
// Holds the default pyramid geometry, window size, pipeline depth, the scan
// FSM state type and a helper deciding whether a pyramid level can hold a window.
package vj_pkg;

  localparam int unsigned NUM_LEVELS = 13;
  localparam int unsigned WIN        = 24;
  localparam int unsigned COORD_W    = 32;
  localparam int unsigned PIPE_DEPTH = 2914;

  // Index 0 is the full-resolution image; each level is roughly 1/1.2 of the previous.
  localparam logic [NUM_LEVELS-1:0][15:0] PYRAMID_WIDTHS = {
    16'd43, 16'd51, 16'd62, 16'd74, 16'd89, 16'd107, 16'd128,
    16'd154, 16'd185, 16'd222, 16'd267, 16'd320, 16'd384
  };
  localparam logic [NUM_LEVELS-1:0][15:0] PYRAMID_HEIGHTS = {
    16'd32, 16'd39, 16'd46, 16'd56, 16'd67, 16'd80, 16'd96,
    16'd116, 16'd139, 16'd167, 16'd200, 16'd240, 16'd288
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SCAN  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

  // A level is usable when a full window fits in both dimensions.
  function automatic logic level_usable(input logic [15:0] w, input logic [15:0] h,
                                        input int unsigned win);
    return (32'(w) >= win) && (32'(h) >= win);
  endfunction

endpackage

// File: rtl/level_skip_finder.sv
// Combinational lookup over the pyramid geometry.
// Ports:
//   level        in   current pyramid level
//   first_level  out  lowest usable level (0 when none is usable)
//   any_usable   out  at least one level can hold a window
//   next_level   out  lowest usable level strictly above 'level'
//   last_level   out  no usable level exists above 'level'
module level_skip_finder #(
  parameter int unsigned NUM_LEVELS = vj_pkg::NUM_LEVELS,
  parameter int unsigned WIN        = vj_pkg::WIN,
  parameter logic [NUM_LEVELS-1:0][15:0] LEVEL_WIDTHS  = vj_pkg::PYRAMID_WIDTHS,
  parameter logic [NUM_LEVELS-1:0][15:0] LEVEL_HEIGHTS = vj_pkg::PYRAMID_HEIGHTS
) (
  input  logic [3:0] level,
  output logic [3:0] first_level,
  output logic       any_usable,
  output logic [3:0] next_level,
  output logic       last_level
);
  import vj_pkg::*;

  logic [NUM_LEVELS-1:0] usable;

  always_comb begin
    usable = '0;
    for (int l = 0; l < int'(NUM_LEVELS); l++) begin
      usable[l] = level_usable(LEVEL_WIDTHS[l], LEVEL_HEIGHTS[l], WIN);
    end
  end

  // Walk downwards so the lowest matching level is the one left standing.
  always_comb begin
    first_level = '0;
    any_usable  = 1'b0;
    next_level  = '0;
    last_level  = 1'b1;
    for (int l = int'(NUM_LEVELS) - 1; l >= 0; l--) begin
      if (usable[l]) begin
        first_level = 4'(l);
        any_usable  = 1'b1;
        if (4'(l) > level) begin
          next_level = 4'(l);
          last_level = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/scan_window_sequencer.sv
// Scan control FSM feeding vj_pipeline: walks every WIN x WIN window over every
// usable pyramid level (column inner, then row, then level), then keeps the
// pipeline clocking for PIPE_DEPTH cycles so the last verdict drains out.
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   start                   begin a frame scan (ignored while busy)
//   stall                   freeze indices, count and pipeline (SCAN/DRAIN only)
//   busy, done              frame in progress / one-cycle completion pulse
//   img_index, row_index,
//   col_index               current window position
//   vj_enable, vj_reset     pipeline advance / one-cycle pipeline clear
//   scanning_window_coords  {col+WIN-1, col, row+WIN-1, row}
//   window_count            windows issued this frame
// All outputs are registered; a stall sampled on an edge shows up in the
// following cycle's outputs.
module scan_window_sequencer #(
  parameter int unsigned NUM_LEVELS = vj_pkg::NUM_LEVELS,
  parameter int unsigned WIN        = vj_pkg::WIN,
  parameter int unsigned COORD_W    = vj_pkg::COORD_W,
  parameter int unsigned PIPE_DEPTH = vj_pkg::PIPE_DEPTH,
  parameter logic [NUM_LEVELS-1:0][15:0] LEVEL_WIDTHS  = vj_pkg::PYRAMID_WIDTHS,
  parameter logic [NUM_LEVELS-1:0][15:0] LEVEL_HEIGHTS = vj_pkg::PYRAMID_HEIGHTS
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              img_index,
  output logic [COORD_W-1:0]      row_index,
  output logic [COORD_W-1:0]      col_index,
  output logic                    vj_enable,
  output logic                    vj_reset,
  output logic [3:0][COORD_W-1:0] scanning_window_coords,
  output logic [COORD_W-1:0]      window_count
);
  import vj_pkg::*;

  localparam int unsigned DRAIN_W = $clog2(PIPE_DEPTH + 1);

  scan_state_t               state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      en_q, en_d;
  logic                      vjrst_q, vjrst_d;
  logic [3:0]                img_q, img_d;
  logic [COORD_W-1:0]        row_q, row_d;
  logic [COORD_W-1:0]        col_q, col_d;
  logic [COORD_W-1:0]        count_q, count_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic [3:0][COORD_W-1:0]   coords_q, coords_d;
  logic                      load_idx;

  logic [3:0]                first_level, next_level;
  logic                      any_usable, last_level;
  logic [COORD_W-1:0]        cur_w, cur_h;
  logic                      col_end, row_end, win_last;

  level_skip_finder #(
    .NUM_LEVELS    (NUM_LEVELS),
    .WIN           (WIN),
    .LEVEL_WIDTHS  (LEVEL_WIDTHS),
    .LEVEL_HEIGHTS (LEVEL_HEIGHTS)
  ) u_skip (
    .level       (img_q),
    .first_level (first_level),
    .any_usable  (any_usable),
    .next_level  (next_level),
    .last_level  (last_level)
  );

  always_comb begin
    cur_w = '0;
    cur_h = '0;
    for (int l = 0; l < int'(NUM_LEVELS); l++) begin
      if (img_q == 4'(l)) begin
        cur_w = COORD_W'(LEVEL_WIDTHS[l]);
        cur_h = COORD_W'(LEVEL_HEIGHTS[l]);
      end
    end
  end

  // Only evaluated on usable levels, so the subtractions cannot wrap.
  assign col_end  = col_q >= (cur_w - COORD_W'(WIN));
  assign row_end  = row_q >= (cur_h - COORD_W'(WIN));
  assign win_last = col_end && row_end && last_level;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    en_d     = 1'b0;
    vjrst_d  = 1'b0;
    img_d    = img_q;
    row_d    = row_q;
    col_d    = col_q;
    count_d  = count_q;
    drain_d  = drain_q;
    load_idx = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CLEAR;
          busy_d   = 1'b1;
          vjrst_d  = 1'b1;
          count_d  = '0;
          drain_d  = '0;
          img_d    = any_usable ? first_level : 4'd0;
          row_d    = '0;
          col_d    = '0;
          load_idx = 1'b1;
        end
      end
      CLEAR: begin
        en_d = 1'b1;
        if (any_usable) begin
          state_d = SCAN;
          count_d = COORD_W'(1);
        end else begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(1);
        end
      end
      SCAN: begin
        if (!stall) begin
          en_d = 1'b1;
          if (win_last) begin
            state_d = DRAIN;
            drain_d = DRAIN_W'(1);
          end else begin
            count_d  = count_q + 1'b1;
            load_idx = 1'b1;
            if (!col_end) begin
              col_d = col_q + 1'b1;
            end else if (!row_end) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              img_d = next_level;
              row_d = '0;
              col_d = '0;
            end
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (drain_q == DRAIN_W'(PIPE_DEPTH)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            en_d    = 1'b1;
            drain_d = drain_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Coordinates track the indices only when a new window is loaded, so they
  // stay zero out of reset.
  always_comb begin
    coords_d = coords_q;
    if (load_idx) begin
      coords_d[0] = row_d;
      coords_d[1] = row_d + COORD_W'(WIN - 1);
      coords_d[2] = col_d;
      coords_d[3] = col_d + COORD_W'(WIN - 1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      vjrst_q  <= 1'b0;
      img_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      count_q  <= '0;
      drain_q  <= '0;
      coords_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      vjrst_q  <= vjrst_d;
      img_q    <= img_d;
      row_q    <= row_d;
      col_q    <= col_d;
      count_q  <= count_d;
      drain_q  <= drain_d;
      coords_q <= coords_d;
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign vj_enable              = en_q;
  assign vj_reset               = vjrst_q;
  assign img_index              = img_q;
  assign row_index              = row_q;
  assign col_index              = col_q;
  assign window_count           = count_q;
  assign scanning_window_coords = coords_q;

endmodule

// File: tb/tb_scan_window_sequencer.sv
// Bench for scan_window_sequencer: three small two-level configurations
// (both levels usable, level 1 too narrow, nothing usable) driven by shared
// inputs; each frame is checked against a window list built from the pyramid
// geometry, with random or scheduled stalls.
module tb_scan_window_sequencer;

  localparam int WIN = 24;
  localparam int PD  = 4;

  logic clock = 1'b0;
  logic reset_n, start, stall;

  logic             busy_v [3];
  logic             done_v [3];
  logic             en_v   [3];
  logic             rst_v  [3];
  logic [3:0]       img_v  [3];
  logic [31:0]      row_v  [3];
  logic [31:0]      col_v  [3];
  logic [31:0]      cnt_v  [3];
  logic [3:0][31:0] crd_v  [3];

  int cfg_w [3][2] = '{'{32, 26}, '{32, 20}, '{10, 20}};
  int cfg_h [3][2] = '{'{28, 25}, '{28, 25}, '{28, 25}};

  typedef struct {
    int lvl;
    int row;
    int col;
  } win_t;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  scan_window_sequencer #(
    .NUM_LEVELS (2), .WIN (24), .COORD_W (32), .PIPE_DEPTH (4),
    .LEVEL_WIDTHS ({16'd26, 16'd32}), .LEVEL_HEIGHTS ({16'd25, 16'd28})
  ) u_dut0 (
    .clock (clock), .reset_n (reset_n), .start (start), .stall (stall),
    .busy (busy_v[0]), .done (done_v[0]), .img_index (img_v[0]),
    .row_index (row_v[0]), .col_index (col_v[0]), .vj_enable (en_v[0]),
    .vj_reset (rst_v[0]), .scanning_window_coords (crd_v[0]), .window_count (cnt_v[0])
  );

  scan_window_sequencer #(
    .NUM_LEVELS (2), .WIN (24), .COORD_W (32), .PIPE_DEPTH (4),
    .LEVEL_WIDTHS ({16'd20, 16'd32}), .LEVEL_HEIGHTS ({16'd25, 16'd28})
  ) u_dut1 (
    .clock (clock), .reset_n (reset_n), .start (start), .stall (stall),
    .busy (busy_v[1]), .done (done_v[1]), .img_index (img_v[1]),
    .row_index (row_v[1]), .col_index (col_v[1]), .vj_enable (en_v[1]),
    .vj_reset (rst_v[1]), .scanning_window_coords (crd_v[1]), .window_count (cnt_v[1])
  );

  scan_window_sequencer #(
    .NUM_LEVELS (2), .WIN (24), .COORD_W (32), .PIPE_DEPTH (4),
    .LEVEL_WIDTHS ({16'd20, 16'd10}), .LEVEL_HEIGHTS ({16'd25, 16'd28})
  ) u_dut2 (
    .clock (clock), .reset_n (reset_n), .start (start), .stall (stall),
    .busy (busy_v[2]), .done (done_v[2]), .img_index (img_v[2]),
    .row_index (row_v[2]), .col_index (col_v[2]), .vj_enable (en_v[2]),
    .vj_reset (rst_v[2]), .scanning_window_coords (crd_v[2]), .window_count (cnt_v[2])
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input int s);
    check_eq("zero_busy", 64'(busy_v[s]), 0);
    check_eq("zero_done", 64'(done_v[s]), 0);
    check_eq("zero_enable", 64'(en_v[s]), 0);
    check_eq("zero_vj_reset", 64'(rst_v[s]), 0);
    check_eq("zero_img", 64'(img_v[s]), 0);
    check_eq("zero_row", 64'(row_v[s]), 0);
    check_eq("zero_col", 64'(col_v[s]), 0);
    check_eq("zero_count", 64'(cnt_v[s]), 0);
    for (int i = 0; i < 4; i++) check_eq("zero_coords", 64'(crd_v[s][i]), 0);
  endtask

  // mode 0: no stall, 1: random stall, 2: 3 stalls at window 10 and 2 in drain.
  // rst_at >= 0 pulls reset_n while window rst_at is presented.
  task automatic run_frame(input int s, input int mode, input int rst_at, input bit extra_start);
    win_t q[$];
    int   n, pos, hold, cyc, k;
    bit   stalled, fin, st;
    q = {};
    for (int l = 0; l < 2; l++) begin
      if (cfg_w[s][l] >= WIN && cfg_h[s][l] >= WIN) begin
        for (int r = 0; r <= cfg_h[s][l] - WIN; r++)
          for (int c = 0; c <= cfg_w[s][l] - WIN; c++) q.push_back('{l, r, c});
      end
    end
    n = q.size();

    // Start together with a random stall: start must still be taken.
    start = 1'b1;
    stall = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("clear_vj_reset", 64'(rst_v[s]), 1);
    check_eq("clear_busy", 64'(busy_v[s]), 1);
    check_eq("clear_enable", 64'(en_v[s]), 0);
    check_eq("clear_done", 64'(done_v[s]), 0);
    check_eq("clear_count", 64'(cnt_v[s]), 0);
    stall = 1'($urandom_range(0, 1));
    @(posedge clock); #1;

    pos = 0; hold = 0; stalled = 1'b0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 400) begin
      cyc++;
      if (pos < n + PD) begin
        check_eq("vj_enable", 64'(en_v[s]), 64'(!stalled));
        check_eq("busy", 64'(busy_v[s]), 1);
        check_eq("done_early", 64'(done_v[s]), 0);
        check_eq("vj_reset_low", 64'(rst_v[s]), 0);
        if (n > 0) begin
          k = (pos < n) ? pos : n - 1;
          check_eq("img_index", 64'(img_v[s]), 64'(q[k].lvl));
          check_eq("row_index", 64'(row_v[s]), 64'(q[k].row));
          check_eq("col_index", 64'(col_v[s]), 64'(q[k].col));
          check_eq("coord_row", 64'(crd_v[s][0]), 64'(q[k].row));
          check_eq("coord_row_end", 64'(crd_v[s][1]), 64'(q[k].row + WIN - 1));
          check_eq("coord_col", 64'(crd_v[s][2]), 64'(q[k].col));
          check_eq("coord_col_end", 64'(crd_v[s][3]), 64'(q[k].col + WIN - 1));
        end else begin
          check_eq("img_none", 64'(img_v[s]), 0);
          check_eq("row_none", 64'(row_v[s]), 0);
          check_eq("col_none", 64'(col_v[s]), 0);
        end
        check_eq("window_count", 64'(cnt_v[s]), 64'((pos < n) ? pos + 1 : n));
        if (rst_at >= 0 && pos == rst_at && !stalled) begin
          stall   = 1'b0;
          reset_n = 1'b0;
          @(posedge clock); #1;
          reset_n = 1'b1;
          check_zero(s);
          repeat (6) begin
            @(posedge clock); #1;
            check_eq("no_done_after_rst", 64'(done_v[s]), 0);
            check_eq("idle_after_rst", 64'(busy_v[s]), 0);
          end
          return;
        end
        start = extra_start && (pos == 5);
        case (mode)
          1:       st = ($urandom_range(0, 3) == 0);
          2:       st = ((pos == 10) && (hold < 3)) || ((pos == n + 1) && (hold < 2));
          default: st = 1'b0;
        endcase
        stall = st;
        @(posedge clock); #1;
        start = 1'b0;
        if (st) begin
          stalled = 1'b1;
          hold++;
        end else begin
          stalled = 1'b0;
          hold = 0;
          pos++;
        end
      end else begin
        check_eq("done_pulse", 64'(done_v[s]), 1);
        check_eq("done_busy", 64'(busy_v[s]), 1);
        check_eq("done_enable", 64'(en_v[s]), 0);
        check_eq("final_count", 64'(cnt_v[s]), 64'(n));
        stall = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        check_eq("post_done", 64'(done_v[s]), 0);
        check_eq("post_busy", 64'(busy_v[s]), 0);
        check_eq("post_enable", 64'(en_v[s]), 0);
        fin = 1'b1;
      end
    end
    if (!fin) check_eq("frame_timeout", 0, 1);
    stall = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    stall   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 3; s++) check_zero(s);
    reset_n = 1'b1;
    repeat (10) begin
      stall = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      check_zero(0);
    end
    stall = 1'b0;

    run_frame(0, 0, -1, 1'b0);
    run_frame(0, 2, -1, 1'b0);
    run_frame(0, 1, -1, 1'b1);
    run_frame(0, 1, 20, 1'b0);
    run_frame(1, 1, -1, 1'b0);
    run_frame(1, 0, -1, 1'b0);
    run_frame(2, 0, -1, 1'b0);
    run_frame(2, 1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
